frame_tx_mii: RTL

//  Downstream stage of FRAME_FIFO on the repeater's transmit side. Pops bytes
//  and their EOD tag from the FIFO read port and serialises each frame onto a
//  4-bit MII transmit interface: preamble, SFD, payload low nibble first, then
//  an enforced inter-frame gap. A FIFO underrun mid-frame is reported on
//  tx_er; the rest of that frame is then drained and discarded.

---
 rtl/frame_tx_mii.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/frame_tx_mii.sv
// MII transmit serialiser: pops framed bytes from FRAME_FIFO and sends
// preamble, SFD and payload nibbles, with underrun abort and drain.
`timescale 1ns/1ps
module frame_tx_mii #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_NIBBLES    = 24,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [7:0]       fifo_do,
    input  logic             fifo_eod,
    input  logic             fifo_empty,
    output logic             fifo_re,
    output logic [3:0]       txd,
    output logic             tx_en,
    output logic             tx_er,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [7:0]       underrun_cnt
);

    localparam int PRE_N = 2 * PREAMBLE_BYTES;
    localparam int MAX_N = (PRE_N > IFG_NIBBLES) ? PRE_N : IFG_NIBBLES;
    localparam int TW    = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_ABORT, S_DRAIN, S_IFG
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             hi_q, hi_d;
    logic             urun_q, urun_d;
    logic             re_q;
    logic [8:0]       b_q, b_d;
    logic [3:0]       txd_q, txd_d;
    logic             en_q, en_d;
    logic             er_q, er_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]       ucnt_q, ucnt_d;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        hi_d    = hi_q;
        urun_d  = urun_q;
        fcnt_d  = fcnt_q;
        ucnt_d  = ucnt_q;
        fifo_re = 1'b0;
        // B holds {eod, data} of the byte popped on the previous cycle
        b_d     = re_q ? {fifo_eod, fifo_do} : b_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_re = 1'b1;
                    state_d = S_PRE;
                    tmr_d   = '0;
                end
            end
            S_PRE: begin
                if (tmr_q == TW'(PRE_N - 1)) begin
                    state_d = S_SFD;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_SFD: begin
                if (tmr_q == TW'(1)) begin
                    state_d = S_DATA;
                    hi_d    = 1'b0;
                    urun_d  = 1'b0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_DATA: begin
                if (!hi_q) begin
                    hi_d = 1'b1;
                    if (!b_q[8]) begin
                        if (!fifo_empty) fifo_re = 1'b1;
                        else             urun_d  = 1'b1;
                    end
                end else begin
                    hi_d = 1'b0;
                    if (b_q[8]) begin
                        fcnt_d  = fcnt_q + CNT_W'(1);
                        state_d = S_IFG;
                        tmr_d   = '0;
                    end else if (urun_q) begin
                        state_d = S_ABORT;
                        tmr_d   = '0;
                        if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
                    end
                end
            end
            S_ABORT: begin
                if (tmr_q == TW'(1)) state_d = S_DRAIN;
                else                 tmr_d   = tmr_q + TW'(1);
            end
            S_DRAIN: begin
                // stop popping as soon as the eod byte is visible
                if (re_q && fifo_eod) begin
                    state_d = S_IFG;
                    tmr_d   = '0;
                end else if (!fifo_empty) begin
                    fifo_re = 1'b1;
                end
            end
            S_IFG: begin
                if (tmr_q == TW'(IFG_NIBBLES - 1)) state_d = S_IDLE;
                else                               tmr_d   = tmr_q + TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        if (!arst_n) fifo_re = 1'b0;
    end

    always_comb begin
        txd_d = 4'h0;
        en_d  = 1'b0;
        er_d  = 1'b0;
        case (state_d)
            S_PRE: begin
                en_d  = 1'b1;
                txd_d = 4'h5;
            end
            S_SFD: begin
                en_d  = 1'b1;
                txd_d = (tmr_d == '0) ? 4'h5 : 4'hD;
            end
            S_DATA: begin
                en_d  = 1'b1;
                txd_d = hi_d ? b_d[7:4] : b_d[3:0];
            end
            S_ABORT: begin
                en_d = 1'b1;
                er_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            hi_q    <= 1'b0;
            urun_q  <= 1'b0;
            re_q    <= 1'b0;
            b_q     <= '0;
            txd_q   <= 4'h0;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            fcnt_q  <= '0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            hi_q    <= hi_d;
            urun_q  <= urun_d;
            re_q    <= fifo_re;
            b_q     <= b_d;
            txd_q   <= txd_d;
            en_q    <= en_d;
            er_q    <= er_d;
            fcnt_q  <= fcnt_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign txd          = txd_q;
    assign tx_en        = en_q;
    assign tx_er        = er_q;
    assign frame_cnt    = fcnt_q;
    assign underrun_cnt = ucnt_q;

endmodule
